// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with wait states,
// byte-lane stores and alignment/range error reporting.
module dmem_responder #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);
   localparam int IW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state;
   logic [3:0] cnt;
   logic l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic [3:0] l_wstrb;
   logic [DATA_W-1:0] mem [DEPTH];
   logic acc, a_we, a_err;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic [3:0] a_wstrb;
   logic [IW-1:0] a_idx;
   // with zero wait states the access uses the live request on the accept edge
   always_comb begin
      a_we    = (state == IDLE) ? MemWrite : l_we;
      a_addr  = (state == IDLE) ? addr : l_addr;
      a_wdata = (state == IDLE) ? wdata : l_wdata;
      a_wstrb = (state == IDLE) ? wstrb : l_wstrb;
      a_idx   = a_addr[IW+1:2];
      a_err   = (a_addr[1:0] != 2'b00) || (a_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
      acc     = reset_n && ((state == IDLE) ? (req_valid && WAIT_CYCLES == 0)
                                           : (state == WAIT && cnt == 4'd0));
   end
   always_ff @(posedge clk)
      if (acc && a_we && !a_err)
         for (int i = 0; i < 4; i++)
            if (a_wstrb[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rdata     <= '0;
         err       <= 1'b0;
         cnt       <= 4'd0;
         l_we      <= 1'b0;
         l_addr    <= '0;
         l_wdata   <= '0;
         l_wstrb   <= 4'd0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               l_we      <= MemWrite;
               l_addr    <= addr;
               l_wdata   <= wdata;
               l_wstrb   <= wstrb;
               req_ready <= 1'b0;
               if (WAIT_CYCLES == 0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  state <= WAIT;
                  cnt   <= 4'(WAIT_CYCLES - 1);
               end
            end
            WAIT: if (cnt == 4'd0) begin
               state     <= RESP;
               rsp_valid <= 1'b1;
            end else cnt <= cnt - 4'd1;
            RESP: if (rsp_ready) begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
         if (acc) begin
            rdata <= (a_we || a_err) ? '0 : mem[a_idx];
            err   <= a_err;
         end
      end
   end
endmodule
